// File: rtl/progressive_mux_sequencer_if.sv
// Control/status bundle between the crossfade sequencer and whoever drives it.
// The sequencer attaches through the slave modport; the driver side uses master.
interface progressive_mux_sequencer_if #(
  parameter int ALPHA_W = 5
);
  logic               enable_3M;
  logic               req_b;
  logic               force_a;
  logic [ALPHA_W-1:0] alpha_sequence;
  logic               busy;
  logic               sel_b;
  logic               done;

  modport master (
    output enable_3M, req_b, force_a,
    input  alpha_sequence, busy, sel_b, done
  );

  modport slave (
    input  enable_3M, req_b, force_a,
    output alpha_sequence, busy, sel_b, done
  );
endinterface

// File: rtl/progressive_mux_sequencer.sv
// Generates the alpha crossfade coefficient for progressive_mux: ramps between
// data_a (0) and data_b (ALPHA_MAX), advancing only on enable_3M ticks.
module progressive_mux_sequencer #(
  parameter int ALPHA_W    = 5,
  parameter int ALPHA_MAX  = 16,
  parameter int STEP_DIV   = 1,
  parameter int HOLD_TICKS = 64,
  parameter int HOLD_W     = 8
) (
  input logic                        clk,
  input logic                        reset,
  progressive_mux_sequencer_if.slave seq
);

  localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [ALPHA_W-1:0] ALPHA_TOP = ALPHA_W'(ALPHA_MAX);
  localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(STEP_DIV - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_TICKS);

  typedef enum logic [1:0] {
    IDLE_A    = 2'd0,
    RAMP_UP   = 2'd1,
    IDLE_B    = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [ALPHA_W-1:0] alpha, alpha_nxt, alpha_inc, alpha_dec;
  logic [STEP_W-1:0]  step_cnt, step_nxt;
  logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
  logic               done_r, done_nxt;
  logic               busy_r, sel_b_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE_A;
      alpha    <= '0;
      step_cnt <= '0;
      hold_cnt <= '0;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
      sel_b_r  <= 1'b0;
    end else begin
      state    <= state_nxt;
      alpha    <= alpha_nxt;
      step_cnt <= step_nxt;
      hold_cnt <= hold_nxt;
      done_r   <= done_nxt;
      busy_r   <= (state_nxt == RAMP_UP) || (state_nxt == RAMP_DOWN);
      sel_b_r  <= (state_nxt == IDLE_B);
    end
  end

  // A reversal right at an endpoint would otherwise step past it, so the
  // increment/decrement are clamped and hitting the clamp ends the ramp.
  always_comb begin
    state_nxt = state;
    alpha_nxt = alpha;
    step_nxt  = step_cnt;
    hold_nxt  = hold_cnt;
    done_nxt  = 1'b0;
    alpha_inc = (alpha >= ALPHA_TOP) ? ALPHA_TOP : alpha + ALPHA_W'(1);
    alpha_dec = (alpha == '0) ? '0 : alpha - ALPHA_W'(1);

    if (seq.enable_3M) begin
      if (seq.force_a) begin
        state_nxt = IDLE_A;
        alpha_nxt = '0;
        step_nxt  = '0;
        hold_nxt  = HOLD_LOAD;
      end else begin
        case (state)
          IDLE_A: begin
            if (hold_cnt != '0) begin
              hold_nxt = hold_cnt - HOLD_W'(1);
            end else if (seq.req_b) begin
              state_nxt = RAMP_UP;
              step_nxt  = '0;
            end
          end
          IDLE_B: begin
            if (hold_cnt != '0) begin
              hold_nxt = hold_cnt - HOLD_W'(1);
            end else if (!seq.req_b) begin
              state_nxt = RAMP_DOWN;
              step_nxt  = '0;
            end
          end
          RAMP_UP: begin
            if (!seq.req_b) begin
              state_nxt = RAMP_DOWN;
              step_nxt  = '0;
            end else if (step_cnt == STEP_LAST) begin
              alpha_nxt = alpha_inc;
              step_nxt  = '0;
              if (alpha_inc == ALPHA_TOP) begin
                state_nxt = IDLE_B;
                done_nxt  = 1'b1;
                hold_nxt  = HOLD_LOAD;
              end
            end else begin
              step_nxt = step_cnt + STEP_W'(1);
            end
          end
          RAMP_DOWN: begin
            if (seq.req_b) begin
              state_nxt = RAMP_UP;
              step_nxt  = '0;
            end else if (step_cnt == STEP_LAST) begin
              alpha_nxt = alpha_dec;
              step_nxt  = '0;
              if (alpha_dec == '0) begin
                state_nxt = IDLE_A;
                done_nxt  = 1'b1;
                hold_nxt  = HOLD_LOAD;
              end
            end else begin
              step_nxt = step_cnt + STEP_W'(1);
            end
          end
          default: begin
            state_nxt = IDLE_A;
            alpha_nxt = '0;
            step_nxt  = '0;
            hold_nxt  = '0;
          end
        endcase
      end
    end
  end

  assign seq.alpha_sequence = alpha;
  assign seq.busy           = busy_r;
  assign seq.sel_b          = sel_b_r;
  assign seq.done           = done_r;

endmodule

// File: tb/tb_progressive_mux_sequencer.sv
// Scoreboard bench: each issued tick queues its expected outputs, and per-instance
// monitors compare them on the falling edge after the tick lands.
module tb_progressive_mux_sequencer;

  typedef struct packed {
    logic [4:0] alpha;
    logic       busy;
    logic       sel_b;
    logic       done;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic tick_a;
  logic tick_c;
  exp_t q_a[$];
  exp_t q_c[$];

  progressive_mux_sequencer_if #(.ALPHA_W(5)) ifa ();
  progressive_mux_sequencer_if #(.ALPHA_W(5)) ifc ();

  progressive_mux_sequencer #(
    .ALPHA_W(5), .ALPHA_MAX(16), .STEP_DIV(1), .HOLD_TICKS(4), .HOLD_W(8)
  ) dut_a (
    .clk(clk), .reset(reset), .seq(ifa)
  );

  progressive_mux_sequencer #(
    .ALPHA_W(5), .ALPHA_MAX(16), .STEP_DIV(3), .HOLD_TICKS(4), .HOLD_W(8)
  ) dut_c (
    .clk(clk), .reset(reset), .seq(ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Called at posedge+1; the tick lands on the next posedge, then 7 idle clocks follow.
  task automatic apply_stimulus(input bit inst, input logic req, input logic frc,
                                input int alpha, input logic busy, input logic sel,
                                input logic dn);
    exp_t e;
    e.alpha = 5'(alpha);
    e.busy  = busy;
    e.sel_b = sel;
    e.done  = dn;
    if (inst == 1'b0) begin
      q_a.push_back(e);
      ifa.req_b = req; ifa.force_a = frc; ifa.enable_3M = 1'b1;
    end else begin
      q_c.push_back(e);
      ifc.req_b = req; ifc.force_a = frc; ifc.enable_3M = 1'b1;
    end
    @(posedge clk);
    #1;
    ifa.enable_3M = 1'b0;
    ifc.enable_3M = 1'b0;
    repeat (7) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    tick_a <= ifa.enable_3M;
    tick_c <= ifc.enable_3M;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (tick_a) begin
        if (q_a.size() == 0) begin
          check_output("a_unexpected_tick", 1, 0);
        end else begin
          e = q_a.pop_front();
          check_output("a_alpha", int'(ifa.alpha_sequence), int'(e.alpha));
          check_output("a_busy", int'(ifa.busy), int'(e.busy));
          check_output("a_sel_b", int'(ifa.sel_b), int'(e.sel_b));
          check_output("a_done", int'(ifa.done), int'(e.done));
        end
      end else begin
        check_output("a_done_idle", int'(ifa.done), 0);
      end
      if (tick_c) begin
        if (q_c.size() == 0) begin
          check_output("c_unexpected_tick", 1, 0);
        end else begin
          e = q_c.pop_front();
          check_output("c_alpha", int'(ifc.alpha_sequence), int'(e.alpha));
          check_output("c_busy", int'(ifc.busy), int'(e.busy));
          check_output("c_sel_b", int'(ifc.sel_b), int'(e.sel_b));
          check_output("c_done", int'(ifc.done), int'(e.done));
        end
      end else begin
        check_output("c_done_idle", int'(ifc.done), 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    ifa.enable_3M = 1'b0; ifa.req_b = 1'b1; ifa.force_a = 1'b0;
    ifc.enable_3M = 1'b0; ifc.req_b = 1'b0; ifc.force_a = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_output("reset_alpha", int'(ifa.alpha_sequence), 0);
    check_output("reset_busy", int'(ifa.busy), 0);
    check_output("reset_sel_b", int'(ifa.sel_b), 0);
    check_output("reset_done", int'(ifa.done), 0);
    check_output("reset_c_alpha", int'(ifc.alpha_sequence), 0);

    // Full ramp up: entry tick keeps alpha at 0, then one step per tick.
    apply_stimulus(0, 1, 0, 0, 1, 0, 0);
    for (int a = 1; a <= 15; a++) apply_stimulus(0, 1, 0, a, 1, 0, 0);
    apply_stimulus(0, 1, 0, 16, 0, 1, 1);

    // Hold-off in IDLE_B, then ramp down to A.
    for (int k = 0; k < 4; k++) apply_stimulus(0, 0, 0, 16, 0, 1, 0);
    apply_stimulus(0, 0, 0, 16, 1, 0, 0);
    for (int a = 15; a >= 1; a--) apply_stimulus(0, 0, 0, a, 1, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 1);

    // Reversal at alpha 9.
    for (int k = 0; k < 4; k++) apply_stimulus(0, 1, 0, 0, 0, 0, 0);
    apply_stimulus(0, 1, 0, 0, 1, 0, 0);
    for (int a = 1; a <= 9; a++) apply_stimulus(0, 1, 0, a, 1, 0, 0);
    apply_stimulus(0, 0, 0, 9, 1, 0, 0);
    for (int a = 8; a >= 1; a--) apply_stimulus(0, 0, 0, a, 1, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 1);

    // force_a at alpha 11, held for two ticks, then hold-off before restart.
    for (int k = 0; k < 4; k++) apply_stimulus(0, 1, 0, 0, 0, 0, 0);
    apply_stimulus(0, 1, 0, 0, 1, 0, 0);
    for (int a = 1; a <= 11; a++) apply_stimulus(0, 1, 0, a, 1, 0, 0);
    apply_stimulus(0, 1, 1, 0, 0, 0, 0);
    apply_stimulus(0, 1, 1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) apply_stimulus(0, 1, 0, 0, 0, 0, 0);
    apply_stimulus(0, 1, 0, 0, 1, 0, 0);
    apply_stimulus(0, 1, 0, 1, 1, 0, 0);

    // Reset mid-ramp aborts without a done pulse and clears the hold-off.
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_output("midreset_alpha", int'(ifa.alpha_sequence), 0);
    check_output("midreset_busy", int'(ifa.busy), 0);
    check_output("midreset_done", int'(ifa.done), 0);
    apply_stimulus(0, 1, 0, 0, 1, 0, 0);
    apply_stimulus(0, 1, 0, 1, 1, 0, 0);
    ifa.req_b = 1'b0;

    // STEP_DIV=3: alpha after tick t is (t-1)/3, ending on tick 49, with a strobe gap.
    for (int t = 1; t <= 49; t++) begin
      apply_stimulus(1, 1, 0, (t - 1) / 3, (t < 49), (t == 49), (t == 49));
      if (t == 20) begin
        repeat (20) @(posedge clk);
        #1;
        check_output("c_gap_alpha", int'(ifc.alpha_sequence), 6);
        check_output("c_gap_busy", int'(ifc.busy), 1);
      end
    end

    repeat (4) @(posedge clk);
    #1;
    check_output("a_queue_drained", q_a.size(), 0);
    check_output("c_queue_drained", q_c.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
